// File: rtl/hex_digit_scheduler.sv
// Round-robin sharing of one BCD-to-7-segment decoder across NDIG digits.
// Writes mark a digit dirty; the scheduler commits one dirty digit per cycle.
module hex_digit_scheduler #(
    parameter int NDIG = 6,
    parameter int IW   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IW-1:0]     wr_idx,
    input  logic [3:0]        wr_data,
    output logic              wr_err,
    output logic              busy,
    output logic [7*NDIG-1:0] hex
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DEC  = 1'b1;

    logic [0:0]      state;
    logic [3:0]      digit [NDIG];
    logic [NDIG-1:0] dirty;
    logic [NDIG-1:0] wr_set;
    logic [NDIG-1:0] cur_oh;
    logic [NDIG-1:0] nxt_mask;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   cur_inc;
    logic            wr_fire;
    logic            idx_ok;
    logic [6:0]      seg;
    logic [IW:0]     idle_pick;
    logic [IW:0]     dec_pick;

    // {found, index} of the first set bit searching upward from s, wrapping
    function automatic logic [IW:0] pick(input logic [NDIG-1:0] m,
                                         input logic [IW-1:0]   s);
        logic [IW:0] r;
        int j;
        r = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            j = int'(s) + i;
            if (j >= NDIG) j = j - NDIG;
            if (m[j]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    always_comb begin
        wr_fire = wr_valid & wr_ready;
        idx_ok  = {1'b0, wr_idx} < (IW+1)'(NDIG);
        wr_set  = '0;
        cur_oh  = '0;
        if (wr_fire && idx_ok) wr_set[wr_idx] = 1'b1;
        cur_oh[cur] = 1'b1;
        cur_inc   = (cur == IW'(NDIG - 1)) ? '0 : cur + 1'b1;
        // same-cycle writes to other digits join the next-digit search
        nxt_mask  = (dirty | wr_set) & ~cur_oh;
        idle_pick = pick(dirty, ptr);
        dec_pick  = pick(nxt_mask, cur_inc);
        busy      = (|dirty) | (state == DEC);
    end

    always_comb begin
        seg = 7'b1111111;
        case (digit[cur])
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            dirty    <= '0;
            hex      <= '1;
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
            for (int d = 0; d < NDIG; d++) digit[d] <= 4'hF;
        end else begin
            wr_ready <= 1'b1;
            wr_err   <= wr_fire & ~idx_ok;
            for (int d = 0; d < NDIG; d++)
                if (wr_set[d]) digit[d] <= wr_data;
            case (state)
                IDLE: begin
                    dirty <= dirty | wr_set;
                    if (idle_pick[IW]) begin
                        state <= DEC;
                        cur   <= idle_pick[IW-1:0];
                    end
                end
                DEC: begin
                    // a write to cur wins, so the digit is rescheduled
                    hex[int'(cur)*7 +: 7] <= seg;
                    dirty <= (dirty & ~cur_oh) | wr_set;
                    ptr   <= cur_inc;
                    if (dec_pick[IW]) cur <= dec_pick[IW-1:0];
                    else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_digit_scheduler.sv
// Directed bench for hex_digit_scheduler: table vectors plus
// hand-written burst, collision, bad-index and mid-run reset sequences.
module tb_hex_digit_scheduler;

    localparam int NDIG = 6;
    localparam int IW   = 3;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [IW-1:0]     wr_idx;
    logic [3:0]        wr_data;
    logic              wr_err;
    logic              busy;
    logic [7*NDIG-1:0] hex;

    hex_digit_scheduler #(.NDIG(NDIG), .IW(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .busy    (busy),
        .hex     (hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [3:0]    data;
        logic [6:0]    seg;
    } vec_t;

    vec_t              vt [7];
    logic [6:0]        burst_seg [6];
    logic [7*NDIG-1:0] exp_hex;
    int                tests = 0;
    int                fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{3'd0, 4'hC, BLANK};
        vt[1] = '{3'd3, 4'd9, 7'b0010000};
        vt[2] = '{3'd5, 4'd6, 7'b0000010};
        vt[3] = '{3'd1, 4'd3, 7'b0110000};
        vt[4] = '{3'd4, 4'd8, 7'b0000000};
        vt[5] = '{3'd0, 4'd1, 7'b1111001};
        vt[6] = '{3'd2, 4'hF, BLANK};
        burst_seg[0] = 7'b1000000;
        burst_seg[1] = 7'b1111001;
        burst_seg[2] = 7'b0100100;
        burst_seg[3] = 7'b0110000;
        burst_seg[4] = 7'b0011001;
        burst_seg[5] = 7'b0010010;

        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        exp_hex  = '1;

        // reset / blank
        repeat (3) tick();
        check("rst_hex", hex, exp_hex);
        check("rst_ready", wr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", wr_err, 1'b0);
        #2 reset_n = 1'b1;
        check("ready_before_edge", wr_ready, 1'b0);
        tick();
        check("ready_after_release", wr_ready, 1'b1);

        // single write idx 2 = 7
        wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 4'd7;
        tick();
        wr_valid = 1'b0;
        check("single_busy_n1", busy, 1'b1);
        check("single_err", wr_err, 1'b0);
        check("single_hex_n1", hex, exp_hex);
        tick();
        check("single_busy_n2", busy, 1'b1);
        check("single_hex_n2", hex, exp_hex);
        tick();
        exp_hex[14 +: 7] = 7'b1111000;
        check("single_hex_done", hex, exp_hex);
        check("single_busy_done", busy, 1'b0);

        // table vectors
        for (int v = 0; v < 7; v++) begin
            wr_valid = 1'b1; wr_idx = vt[v].idx; wr_data = vt[v].data;
            tick();
            wr_valid = 1'b0;
            tick();
            tick();
            exp_hex[int'(vt[v].idx)*7 +: 7] = vt[v].seg;
            check($sformatf("vec%0d_hex", v), hex, exp_hex);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
        end

        // burst: digits 0..5 written on consecutive edges
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                wr_valid = 1'b1; wr_idx = IW'(k); wr_data = 4'(k);
            end else begin
                wr_valid = 1'b0;
            end
            tick();
            if (k >= 2) exp_hex[(k-2)*7 +: 7] = burst_seg[k-2];
            check($sformatf("burst_hex_k%0d", k), hex, exp_hex);
            check($sformatf("burst_busy_k%0d", k), busy, k < 7);
        end

        // collision on digit 1: commit old 3, then later 8
        wr_valid = 1'b1; wr_idx = 3'd1; wr_data = 4'd3;
        tick();
        wr_valid = 1'b0;
        tick();
        wr_valid = 1'b1; wr_idx = 3'd1; wr_data = 4'd8;
        tick();
        wr_valid = 1'b0;
        exp_hex[7 +: 7] = 7'b0110000;
        check("coll_old", hex, exp_hex);
        check("coll_busy", busy, 1'b1);
        tick();
        check("coll_hold", hex, exp_hex);
        tick();
        exp_hex[7 +: 7] = 7'b0000000;
        check("coll_new", hex, exp_hex);
        check("coll_busy_done", busy, 1'b0);

        // out-of-range index
        wr_valid = 1'b1; wr_idx = 3'd7; wr_data = 4'd5;
        tick();
        wr_valid = 1'b0;
        check("badidx_err", wr_err, 1'b1);
        check("badidx_busy", busy, 1'b0);
        tick();
        check("badidx_err_drop", wr_err, 1'b0);
        check("badidx_busy2", busy, 1'b0);
        tick();
        check("badidx_hex", hex, exp_hex);

        // reset while several digits are pending in DEC
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_idx = IW'(k + 2); wr_data = 4'd0;
            tick();
        end
        wr_valid = 1'b0;
        check("midrst_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #2;
        exp_hex = '1;
        check("midrst_hex", hex, exp_hex);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", wr_ready, 1'b0);
        check("midrst_err", wr_err, 1'b0);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("postrst_hex_%0d", k), hex, exp_hex);
            check($sformatf("postrst_busy_%0d", k), busy, 1'b0);
        end
        check("postrst_ready", wr_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_digit_scheduler.md
# hex_digit_scheduler

Shares one BCD-to-seven-segment decoder between NDIG display digits. Requesters write BCD nibbles into per-digit holding registers through a valid/ready port. A round-robin scheduler then feeds each changed ("dirty") digit through the single decoder and latches the resulting active-low segment pattern into that digit's output register. The block sits between board-level control logic (switches, counters) and the HEX display pins, replacing one decoder per digit.

## Interface
- NDIG, 6, number of display digits (2..8)
- IW, 3, digit index width; must satisfy 2^IW >= NDIG

- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high at a rising edge
- wr_idx  in  IW  target digit index
- wr_data  in  4  BCD nibble
- wr_err  out  1  one-cycle pulse after an accepted write with wr_idx >= NDIG
- busy  out  1  high while any digit is dirty or the FSM is in DEC
- hex  out  7*NDIG  segment patterns, active-low, bits 6..0 = segments g..a; digit d occupies hex[7d+6:7d]

## Operation
- Storage:
  - digit[NDIG] holds 4-bit values.
  - dirty[NDIG] holds 1-bit flags.
  - ptr (IW bits) is the round-robin start point.
  - cur (IW bits) is the digit being decoded.
- Accepted write, wr_idx < NDIG: digit[wr_idx] <= wr_data and dirty[wr_idx] <= 1.
- Accepted write, wr_idx >= NDIG: no state change; wr_err pulses.
- Decode table, 0..9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Decode table, 10..15: blank (1111111). The block never emits X.
- FSM states: IDLE and DEC.
  - IDLE: if any dirty bit is set, go to DEC with cur = first dirty index found searching upward from ptr, wrapping modulo NDIG. Otherwise stay in IDLE.
  - DEC: the decoder input is digit[cur]. On exiting the cycle:
    - hex[cur] <= decode(digit[cur]).
    - dirty[cur] <= 0.
    - ptr <= cur+1, wrapping NDIG-1 to 0.
    - If another dirty bit remains set (excluding cur), stay in DEC with cur = next dirty searching from cur+1. Otherwise go to IDLE.
- Simultaneous write to cur during DEC:
  - The commit uses the pre-write value of digit[cur].
  - The write updates digit[cur] and leaves dirty[cur] = 1, so the digit is rescheduled later.
- Simultaneous write to a non-cur digit during DEC: that digit's dirty bit is set and it is eligible in the same-cycle next-digit search.
- wr_ready is 1 in every cycle except while reset_n is low.

## Timing
- Reset (async, reset_n low):
  - hex = all ones (every digit blank).
  - digit = 4'hF and dirty = 0 for every digit.
  - ptr = 0, cur = 0, state = IDLE.
  - wr_ready = 0, wr_err = 0, busy = 0.
- Reset asserted mid-DEC discards pending dirty digits and returns every output to its reset value immediately.
- Latency: for a write accepted at edge N while idle with no other dirty digits:
  - edge N+1: FSM enters DEC.
  - edge N+2: new pattern visible on hex.
- Throughput is one digit committed per cycle while dirty digits remain, with no IDLE bubble between digits.
- Worst-case latency to commit a given digit after its write is NDIG+1 cycles.
- busy rises the cycle after the first accepted write. It falls the cycle after the last commit.
- wr_err is registered: it is high for exactly the one cycle after the offending edge.

## Test plan
- Reset/blank: hold reset_n low, then release. Required: hex = all ones; wr_ready rises the first cycle after release; busy = 0.
- Single write: write idx 2, data 7 at edge N. Required: hex[20:14] = 1111000 after edge N+2; other digits blank; busy high for cycles N+1..N+2.
- Burst round-robin: write digits 0..5 with values 0..5 on consecutive cycles. Required: commits in index order, one per cycle, with no IDLE bubble. Final hex digit d equals the table entry for d.
- Collision: while DEC commits idx 1 (old value 3), write idx 1 = 8 in that same cycle. Required: hex[1] = 0110000, then one later commit to 0000000.
- Invalid data and index: write data 4'hC to idx 0. Required: hex[0] = 1111111, not X. Write idx 7 with NDIG = 6. Required: wr_err pulses for one cycle; no hex change; busy stays 0.
- Reset mid-operation: with 4 digits dirty, pulse reset_n low in the DEC state. Required: all outputs return to reset values and no later commits occur.
